// File: rtl/mcdaq_ctp.sv
// mcdaq_ctp: multi-channel central trigger processor.
// Delays all channels through a common pre-trigger pipeline and evaluates a
// selectable trigger condition on one source channel. An arm/holdoff state
// machine issues single-cycle trigger pulses aligned to the delayed stream.
// Optional feature macro: MCDAQ_CTP_HOLDOFF_EN (holdoff counter + HOLDOFF state).
module mcdaq_ctp #(
    parameter int unsigned PRECISION = 8,
    parameter int unsigned NCHANNELS = 4,
    parameter int unsigned DELAY     = 4,
    parameter int unsigned HOLDOFF_W = 16
) (
    input  logic                            DAQ_Clock,
    input  logic                            Reset,
    input  logic                            DAQ_En,
    input  logic [NCHANNELS*PRECISION-1:0]  DAQ_D,
    output logic [NCHANNELS*PRECISION-1:0]  DAQ_Q,
    output logic                            DAQ_QValid,
    output logic                            DAQ_Trg,
    input  logic [2:0]                      TRG_MODE,
    input  logic [3:0]                      TRG_SRC,
    input  logic [PRECISION-1:0]            TRG_LVL,
    input  logic [HOLDOFF_W-1:0]            TRG_HOLDOFF,
    input  logic                            TRG_Single,
    input  logic                            TRG_Arm,
    input  logic                            TRG_Disarm,
    output logic [1:0]                      TRG_State,
    output logic [15:0]                     TRG_Count
);

    localparam int unsigned DW    = NCHANNELS * PRECISION;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    logic [DW-1:0]        stage_q [DELAY];
    logic                 valid_q;
    logic                 trg_q, trg_d;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PRECISION-1:0] cur_c, prev_c;
    logic                 src_ok_c;
    logic                 cur_ge_c, prev_ge_c;
    logic                 cond_c;

    // Pre-trigger pipeline: all channels advance together on enabled samples.
    always_ff @(posedge DAQ_Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                stage_q[i] <= '0;
            end
        end else if (DAQ_En) begin
            stage_q[0] <= DAQ_D;
            for (int i = 1; i < int'(DELAY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Source channel select: current input sample and previous accepted sample.
    always_comb begin
        cur_c    = '0;
        prev_c   = '0;
        src_ok_c = 1'b0;
        for (int c = 0; c < int'(NCHANNELS); c++) begin
            if (TRG_SRC == 4'(c)) begin
                cur_c    = DAQ_D[c*PRECISION +: PRECISION];
                prev_c   = stage_q[0][c*PRECISION +: PRECISION];
                src_ok_c = 1'b1;
            end
        end
    end

    // Trigger condition decode (unsigned compares).
    always_comb begin
        cur_ge_c  = (cur_c >= TRG_LVL);
        prev_ge_c = (prev_c >= TRG_LVL);
        cond_c    = 1'b0;
        case (TRG_MODE)
            3'd0:    cond_c = 1'b1;
            3'd1:    cond_c = cur_ge_c;
            3'd2:    cond_c = !prev_ge_c && cur_ge_c;
            3'd3:    cond_c = prev_ge_c && !cur_ge_c;
            3'd4:    cond_c = prev_ge_c != cur_ge_c;
            3'd5:    cond_c = cur_c > prev_c;
            3'd6:    cond_c = cur_c < prev_c;
            default: cond_c = 1'b0;
        endcase
        if (!src_ok_c) begin
            cond_c = 1'b0;
        end
    end

`ifdef MCDAQ_CTP_HOLDOFF_EN
    logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;

    // Holdoff counter register.
    always_ff @(posedge DAQ_Clock or posedge Reset) begin
        if (Reset) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end
`else
    logic unused_holdoff;
    assign unused_holdoff = ^TRG_HOLDOFF;
`endif

    // Arm/holdoff next-state and trigger decision; Disarm has top priority.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        trg_d   = 1'b0;
`ifdef MCDAQ_CTP_HOLDOFF_EN
        hcnt_d  = hcnt_q;
`endif
        if (TRG_Disarm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (TRG_Arm) begin
                        state_d = ST_ARMED;
                        count_d = '0;
                    end
                end
                ST_ARMED: begin
                    if (DAQ_En && cond_c) begin
                        trg_d = 1'b1;
                        if (count_q != {CNT_W{1'b1}}) begin
                            count_d = count_q + CNT_W'(1);
                        end
`ifdef MCDAQ_CTP_HOLDOFF_EN
                        if (TRG_HOLDOFF != '0) begin
                            state_d = ST_HOLDOFF;
                            hcnt_d  = TRG_HOLDOFF;
                        end else if (TRG_Single) begin
                            state_d = ST_IDLE;
                        end
`else
                        if (TRG_Single) begin
                            state_d = ST_IDLE;
                        end
`endif
                    end
                end
`ifdef MCDAQ_CTP_HOLDOFF_EN
                ST_HOLDOFF: begin
                    if (DAQ_En) begin
                        hcnt_d = hcnt_q - HOLDOFF_W'(1);
                        if (hcnt_q == HOLDOFF_W'(1)) begin
                            state_d = TRG_Single ? ST_IDLE : ST_ARMED;
                        end
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, count, trigger pulse and sample-valid registers.
    always_ff @(posedge DAQ_Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            trg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            trg_q   <= trg_d;
            valid_q <= DAQ_En;
        end
    end

    assign DAQ_Q      = stage_q[DELAY-1];
    assign DAQ_QValid = valid_q;
    assign DAQ_Trg    = trg_q;
    assign TRG_State  = state_q;
    assign TRG_Count  = count_q;

endmodule

// File: tb/tb_mcdaq_ctp.sv
// Bench for mcdaq_ctp: sample-history model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_mcdaq_ctp;

    localparam int unsigned P   = 8;
    localparam int unsigned NCH = 4;
    localparam int unsigned DLY = 4;
    localparam int unsigned HW  = 16;
    localparam int unsigned DW  = NCH * P;
`ifdef MCDAQ_CTP_HOLDOFF_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] d = '0;
    logic [DW-1:0] q;
    logic          qv, trg;
    logic [2:0]    mode = '0;
    logic [3:0]    src = '0;
    logic [P-1:0]  lvl = '0;
    logic [HW-1:0] hold = '0;
    logic          single = 1'b0, arm = 1'b0, disarm = 1'b0;
    logic [1:0]    st;
    logic [15:0]   cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mcdaq_ctp #(.PRECISION(P), .NCHANNELS(NCH), .DELAY(DLY), .HOLDOFF_W(HW)) dut (
        .DAQ_Clock(clk), .Reset(rst), .DAQ_En(en), .DAQ_D(d), .DAQ_Q(q),
        .DAQ_QValid(qv), .DAQ_Trg(trg), .TRG_MODE(mode), .TRG_SRC(src),
        .TRG_LVL(lvl), .TRG_HOLDOFF(hold), .TRG_Single(single), .TRG_Arm(arm),
        .TRG_Disarm(disarm), .TRG_State(st), .TRG_Count(cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int chan(input logic [DW-1:0] w, input int c);
        return int'(w[c*P +: P]);
    endfunction

    function automatic logic [DW-1:0] mk(input logic [7:0] v);
        return {8'h33, v, 8'h22, 8'h11};
    endfunction

    // Model: history of accepted samples (newest at back) and trigger bookkeeping.
    logic [DW-1:0] m_hist[$];
    int            m_state = 0;
    int            m_count = 0;
    int            m_left = 0;
    logic [DW-1:0] e_q = '0;
    logic          e_valid = 1'b0;
    logic          e_trg = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < int'(DLY); i++) m_hist.push_back('0);
            m_state = 0;
            m_count = 0;
            m_left  = 0;
            e_q     = '0;
            e_valid = 1'b0;
            e_trg   = 1'b0;
        end else begin : model_step
            bit fire;
            int cur, prv, lv;
            fire = 1'b0;
            if (en && int'(src) < int'(NCH)) begin
                cur = chan(d, int'(src));
                prv = chan(m_hist[$], int'(src));
                lv  = int'(lvl);
                case (int'(mode))
                    0: fire = 1'b1;
                    1: fire = cur >= lv;
                    2: fire = (prv < lv) && (cur >= lv);
                    3: fire = (prv >= lv) && (cur < lv);
                    4: fire = ((prv < lv) && (cur >= lv)) || ((prv >= lv) && (cur < lv));
                    5: fire = cur > prv;
                    6: fire = cur < prv;
                    default: fire = 1'b0;
                endcase
            end
            e_trg = 1'b0;
            if (disarm) begin
                m_state = 0;
            end else if (m_state == 0) begin
                if (arm) begin
                    m_state = 1;
                    m_count = 0;
                end
            end else if (m_state == 1) begin
                if (fire) begin
                    e_trg = 1'b1;
                    m_count = (m_count < 65535) ? m_count + 1 : 65535;
                    if (HOLD_EN && hold != 0) begin
                        m_state = 2;
                        m_left  = int'(hold);
                    end else if (single) begin
                        m_state = 0;
                    end
                end
            end else if (en) begin
                m_left--;
                if (m_left == 0) m_state = single ? 0 : 1;
            end
            e_valid = en;
            if (en) begin
                m_hist.push_back(d);
                void'(m_hist.pop_front());
            end
            e_q = m_hist[0];
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("cyc_daq_q", 32'(q), 32'(e_q));
        chk("cyc_qvalid", 32'(qv), 32'(e_valid));
        chk("cyc_trg", 32'(trg), 32'(e_trg));
        chk("cyc_state", 32'(st), 32'(m_state));
        chk("cyc_count", 32'(cnt), 32'(m_count));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ramp [5];
        logic [7:0] post [3];
        logic       en_seq [4];
        ramp   = '{8'h70, 8'h70, 8'h70, 8'h70, 8'h78};
        post   = '{8'h88, 8'h90, 8'h98};
        en_seq = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset held for 3 clocks with random input samples.
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = DW'($urandom);
            tick();
        end
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_qvalid", 32'(qv), 32'h0);
        chk("rst_trg", 32'(trg), 32'h0);
        chk("rst_state", 32'(st), 32'h0);
        chk("rst_count", 32'(cnt), 32'h0);
        rst = 1'b0;
        en  = 1'b0;
        d   = '0;
        tick();

        // Rising cross on channel 2 at 0x80.
        mode = 3'd2; lvl = 8'h80; src = 4'd2; hold = '0; single = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rise_armed", 32'(st), 32'h1);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = mk(ramp[i]);
            tick();
            chk("rise_pre_notrg", 32'(trg), 32'h0);
        end
        d = mk(8'h80);
        tick();
        chk("rise_trg", 32'(trg), 32'h1);
        chk("rise_q_ch2", 32'(q[23:16]), 32'h70);
        chk("rise_count", 32'(cnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            d = mk(post[i]);
            tick();
            chk("rise_post_notrg", 32'(trg), 32'h0);
        end
        chk("rise_q_reach", 32'(q[23:16]), 32'h80);
        chk("rise_q_ch0", 32'(q[7:0]), 32'h11);
        chk("rise_count_final", 32'(cnt), 32'h1);

        // Continuous mode with holdoff of 2.
        en = 1'b0; disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("disarm_idle", 32'(st), 32'h0);
        mode = 3'd0; hold = 16'd2; arm = 1'b1;
        tick();
        arm = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            d = mk(8'(k));
            tick();
`ifdef MCDAQ_CTP_HOLDOFF_EN
            chk("hold_trg", 32'(trg), (k % 3 == 0) ? 32'h1 : 32'h0);
            chk("hold_state", 32'(st), (k % 3 == 2) ? 32'h1 : 32'h2);
`else
            chk("hold_trg", 32'(trg), 32'h1);
            chk("hold_state", 32'(st), 32'h1);
`endif
        end
`ifdef MCDAQ_CTP_HOLDOFF_EN
        chk("hold_count", 32'(cnt), 32'd3);
`else
        chk("hold_count", 32'(cnt), 32'd9);
`endif

        // Level mode, single shot, then re-arm.
        en = 1'b0; disarm = 1'b1;
        tick();
        disarm = 1'b0;
        mode = 3'd1; lvl = 8'h10; single = 1'b1; hold = '0; d = 32'h20202020;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("single_arm_clr", 32'(cnt), 32'h0);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("single_trg", 32'(trg), (k == 0) ? 32'h1 : 32'h0);
            chk("single_state", 32'(st), 32'h0);
        end
        chk("single_count", 32'(cnt), 32'h1);
        en = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rearm_clr", 32'(cnt), 32'h0);
        chk("rearm_state", 32'(st), 32'h1);
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rearm_trg", 32'(trg), (k == 0) ? 32'h1 : 32'h0);
        end
        chk("rearm_count", 32'(cnt), 32'h1);

        // Disarm beats Arm on a qualifying sample; Arm in ARMED is ignored.
        en = 1'b0; single = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("da_armed", 32'(st), 32'h1);
        en = 1'b1; arm = 1'b1; disarm = 1'b1;
        tick();
        arm = 1'b0; disarm = 1'b0; en = 1'b0;
        chk("da_notrg", 32'(trg), 32'h0);
        chk("da_idle", 32'(st), 32'h0);
        arm = 1'b1;
        tick();
        arm = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        chk("da_trg", 32'(trg), 32'h1);
        chk("da_count", 32'(cnt), 32'h1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_arm_state", 32'(st), 32'h1);
        chk("armed_arm_count", 32'(cnt), 32'h1);

        // Enable toggling with an out-of-range source channel.
        mode = 3'd5; src = 4'd5;
        for (int k = 0; k < 4; k++) begin
            en = en_seq[k];
            d  = 32'h01010101 * (k + 2);
            tick();
            chk("tog_qvalid", 32'(qv), 32'(en_seq[k]));
            chk("tog_notrg", 32'(trg), 32'h0);
        end

        // Reset mid-operation, then first sample sees prev = 0.
        mode = 3'd0; src = 4'd0; hold = 16'd5; en = 1'b1;
        tick();
        chk("mid_trg", 32'(trg), 32'h1);
        chk("mid_state", 32'(st), HOLD_EN ? 32'h2 : 32'h1);
        en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'(st), 32'h0);
        chk("mid_rst_count", 32'(cnt), 32'h0);
        chk("mid_rst_q", 32'(q), 32'h0);
        tick();
        rst = 1'b0;
        mode = 3'd2; lvl = 8'h01; hold = '0; arm = 1'b1;
        tick();
        arm = 1'b0; en = 1'b1; d = 32'h00000005;
        tick();
        en = 1'b0;
        chk("post_rst_cross", 32'(trg), 32'h1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
